matrix_output_tx: RTL and testbench
===================================

Name: matrix_output_tx

Overview:
- Counterpart of the UART input path: reads one m x n matrix from matrix RAM and emits it as ASCII decimal text over a byte-level transmit handshake.
- Feeds the existing uart_tx.
- Row format: elements separated by one space (0x20); each row ends with CR LF (0x0D 0x0A).
- Used by the top-level FSM for display and result printout after compute.

Parameters:
ADDR_W, 9, matrix RAM address width
DATA_W, 32, element width, signed two's complement
MAX_DIM, 5, largest legal m or n

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; low forces S_IDLE next edge, clears all outputs
start  in  1  one-cycle request; sampled only in S_IDLE
base_addr  in  ADDR_W  address of element (0,0)
dim_m  in  3  row count, legal 1..MAX_DIM
dim_n  in  3  column count, legal 1..MAX_DIM
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM data, valid exactly one cycle after rd_en
tx_byte  out  8  ASCII byte to transmit
tx_valid  out  1  tx_byte valid
tx_ready  in  1  uart_tx can accept; transfer when tx_valid && tx_ready
busy  out  1  high from accepted start until done pulse
done  out  1  one-cycle pulse after final LF is accepted
dim_err  out  1  one-cycle pulse when start is seen with an illegal dimension

Behaviour:
- Reset / en low: rd_en=0, rd_addr=0, tx_byte=0, tx_valid=0, busy=0, done=0, dim_err=0, state=S_IDLE, row/col counters 0.
- en low mid-transfer is the only case where tx_valid may drop before acceptance.
- start with dim_m or dim_n equal to 0 or above MAX_DIM:
  - dim_err pulses the next cycle.
  - No reads, no bytes; stays in S_IDLE.
- start while busy is ignored.
- Legal start: latch base_addr, dim_m, dim_n; busy=1 next cycle; row i=0, col j=0.
- Address: rd_addr = base_addr + i*dim_n + j, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- States:
  - S_IDLE -> S_FETCH on legal start.
  - S_FETCH: rd_en=1 for one cycle -> S_WAIT.
  - S_WAIT: capture rd_data at end of cycle. Negative value: magnitude = two's-complement negation as unsigned DATA_W (0x80000000 stays 2147483648), go to S_SIGN. Otherwise -> S_CONV.
  - S_SIGN: present '-' (0x2D); on transfer -> S_CONV.
  - S_CONV: digit converter emits digits MSB first with leading zeros suppressed; value 0 emits a single '0'. Each digit is presented as tx_byte = 0x30 + digit. After the last digit transfers: -> S_SEP if j < dim_n-1, else -> S_CR.
  - S_SEP: present 0x20; on transfer j++ -> S_FETCH.
  - S_CR: present 0x0D -> S_LF.
  - S_LF: present 0x0A; on transfer: if i < dim_m-1, then i++, j=0 -> S_FETCH; else -> S_DONE.
  - S_DONE: done=1, busy=0 -> S_IDLE.
- Handshake:
  - tx_byte is stable while tx_valid=1 && tx_ready=0.
  - tx_valid may stay high across back-to-back bytes; a new byte may be presented the cycle after a transfer.
  - No trailing space at row end; no header line.
- Latency:
  - First rd_en one cycle after start.
  - First tx_valid at most 14 cycles after start (converter at most 11 cycles).
  - Byte throughput is limited only by tx_ready, except digit gaps of at most 1 cycle each.
- Exactly one read per element; element order is row-major.

Decomposition:
- Shared package / header:
  - ASCII constants: ASC_0=0x30, ASC_SPACE=0x20, ASC_CR=0x0D, ASC_LF=0x0A, ASC_MINUS=0x2D.
  - State encodings, MAX_DIM.
- Sub-module dec_digit_serializer: sequential compare-subtract against 10^9..10^0, one power per cycle. Ports:
  - load: input, with unsigned 32-bit value.
  - digit / digit_valid / digit_ready: output handshake.
  - last: high with the final digit.
  - Leading-zero suppression is done internally.
- Parent keeps the FSM, address arithmetic, sign handling and separators.

Test Plan:
- 2x3 at base 10, RAM[10..15]=1,2,3,4,5,6, tx_ready always 1 -> bytes "1 2 3\r\n4 5 6\r\n"; done pulses once; rd_addr sequence 10..15.
- 1x2, values 0 and -2147483648 -> "0 -2147483648\r\n" (13 bytes plus separators, CR LF).
- 1x1 value 4294967295 as signed (-1) and 1x1 value 1000000000 -> "-1\r\n" and "1000000000\r\n"; zeros inside the number are preserved.
- tx_ready randomly low 50% during a 5x5 print -> tx_byte is never changed while stalled; byte stream matches the tx_ready=1 run exactly; 25 reads.
- start with dim_m=0, then with dim_n=6 -> dim_err pulse each time, no rd_en, no tx_valid; base_addr=510 with 2x2 -> reads 510, 511, 0, 1.
- Deassert en (and separately rst_n) mid-row -> next cycle all outputs at reset values; a following legal start prints the full matrix correctly.

Source files
------------

// File: rtl/matrix_output_tx_pkg.sv
// matrix_output_tx_pkg: ASCII constants, FSM states and decimal power table for the matrix printer
package matrix_output_tx_pkg;
  localparam int MAX_DIM = 5;
  localparam logic [7:0] ASC_0 = 8'h30;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SIGN, S_CONV, S_SEP, S_CR, S_LF, S_DONE
  } state_e;
  function automatic logic [31:0] pow10(input logic [3:0] p);
    case (p)
      4'd1: return 32'd10;
      4'd2: return 32'd100;
      4'd3: return 32'd1000;
      4'd4: return 32'd10000;
      4'd5: return 32'd100000;
      4'd6: return 32'd1000000;
      4'd7: return 32'd10000000;
      4'd8: return 32'd100000000;
      4'd9: return 32'd1000000000;
      default: return 32'd1;
    endcase
  endfunction
endpackage

// File: rtl/matrix_output_tx_dec_digit_serializer.sv
// dec_digit_serializer: unsigned 32-bit to decimal digits, one power of ten per cycle, MSB first
module dec_digit_serializer
  import matrix_output_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] value,
  output logic [3:0]  digit,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic        last
);
  logic [31:0] rem_q, rem_d, r;
  logic [3:0] p_q, p_d;
  logic started_q, started_d, active_q, active_d;
  always_comb begin
    r = rem_q;
    digit = 4'd0;
    for (int k = 0; k < 9; k++)
      if (r >= pow10(p_q)) begin
        r = r - pow10(p_q);
        digit = digit + 4'd1;
      end
    last = p_q == 4'd0;
    digit_valid = active_q && (digit != 4'd0 || started_q || last);
    rem_d = rem_q;
    p_d = p_q;
    started_d = started_q;
    active_d = active_q;
    if (clr) active_d = 1'b0;
    else if (load) begin
      rem_d = value;
      p_d = 4'd9;
      started_d = 1'b0;
      active_d = 1'b1;
    end else if (active_q && !digit_valid) p_d = p_q - 4'd1;
    else if (digit_valid && digit_ready) begin
      rem_d = r;
      started_d = 1'b1;
      p_d = last ? 4'd0 : p_q - 4'd1;
      active_d = !last;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem_q <= '0;
      p_q <= '0;
      started_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      p_q <= p_d;
      started_q <= started_d;
      active_q <= active_d;
    end
endmodule

// File: rtl/matrix_output_tx.sv
// matrix_output_tx: reads an m x n signed matrix from RAM and streams it as ASCII decimal rows
module matrix_output_tx
  import matrix_output_tx_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              dim_err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0] m_q, m_d, n_q, n_d, i_q, i_d, j_q, j_d;
  logic dim_err_q, dim_err_d, load, xfer, legal, dig_valid, dig_last;
  logic [3:0] dig;
  logic [DATA_W-1:0] mag;
  dec_digit_serializer u_ser (
    .clk(clk), .rst_n(rst_n), .clr(!en), .load(load), .value(32'(mag)),
    .digit(dig), .digit_valid(dig_valid), .digit_ready(tx_ready && state_q == S_CONV),
    .last(dig_last)
  );
  assign rd_en = state_q == S_FETCH;
  assign rd_addr = rd_en ? base_q + ADDR_W'({3'b0, i_q} * {3'b0, n_q}) + ADDR_W'(j_q) : '0;
  assign tx_valid = state_q inside {S_SIGN, S_SEP, S_CR, S_LF} || (state_q == S_CONV && dig_valid);
  assign tx_byte = state_q == S_SIGN ? ASC_MINUS :
                   state_q == S_CONV && dig_valid ? ASC_0 + {4'd0, dig} :
                   state_q == S_SEP ? ASC_SPACE :
                   state_q == S_CR ? ASC_CR :
                   state_q == S_LF ? ASC_LF : 8'h00;
  assign busy = state_q != S_IDLE && state_q != S_DONE;
  assign done = state_q == S_DONE;
  assign dim_err = dim_err_q;
  assign xfer = tx_valid && tx_ready;
  assign legal = dim_m != 3'd0 && dim_m <= 3'(MAX_DIM) && dim_n != 3'd0 && dim_n <= 3'(MAX_DIM);
  assign mag = rd_data[DATA_W-1] ? -rd_data : rd_data;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    m_d = m_q;
    n_d = n_q;
    i_d = i_q;
    j_d = j_q;
    dim_err_d = 1'b0;
    load = 1'b0;
    case (state_q)
      S_IDLE:
        if (start && legal) begin
          state_d = S_FETCH;
          base_d = base_addr;
          m_d = dim_m;
          n_d = dim_n;
          i_d = 3'd0;
          j_d = 3'd0;
        end else dim_err_d = start;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        load = 1'b1;
        state_d = rd_data[DATA_W-1] ? S_SIGN : S_CONV;
      end
      S_SIGN: state_d = xfer ? S_CONV : S_SIGN;
      S_CONV: if (xfer && dig_last) state_d = j_q < n_q - 3'd1 ? S_SEP : S_CR;
      S_SEP:
        if (xfer) begin
          j_d = j_q + 3'd1;
          state_d = S_FETCH;
        end
      S_CR: state_d = xfer ? S_LF : S_CR;
      S_LF:
        if (xfer) begin
          state_d = i_q < m_q - 3'd1 ? S_FETCH : S_DONE;
          i_d = i_q < m_q - 3'd1 ? i_q + 3'd1 : i_q;
          j_d = 3'd0;
        end
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d = S_IDLE;
      i_d = 3'd0;
      j_d = 3'd0;
      dim_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q <= '0;
      m_q <= '0;
      n_q <= '0;
      i_q <= '0;
      j_q <= '0;
      dim_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      m_q <= m_d;
      n_q <= n_d;
      i_q <= i_d;
      j_q <= j_d;
      dim_err_q <= dim_err_d;
    end
endmodule

// File: tb/tb_matrix_output_tx.sv
// tb_matrix_output_tx: directed checks of the matrix ASCII printer against hand-written byte streams
module tb_matrix_output_tx;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, start = 1'b0, tx_ready = 1'b1;
  logic [8:0] base_addr = '0, rd_addr;
  logic [2:0] dim_m = 3'd1, dim_n = 3'd1;
  logic [31:0] rd_data = '0;
  logic [7:0] tx_byte;
  logic rd_en, tx_valid, busy, done, dim_err;
  logic [31:0] ram [512];
  int checks = 0, errors = 0;

  matrix_output_tx dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .base_addr(base_addr),
    .dim_m(dim_m), .dim_n(dim_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .done(done), .dim_err(dim_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  function automatic string vis(input string s);
    string o = "";
    for (int k = 0; k < s.len(); k++)
      if (s[k] == 8'd13) o = {o, "\\r"};
      else if (s[k] == 8'd10) o = {o, "\\n"};
      else o = $sformatf("%s%c", o, s[k]);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chks(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed \"%s\" expected \"%s\"", tag, vis(obs), vis(exp));
    end
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {rd_en, rd_addr, tx_byte, tx_valid, busy, done, dim_err}, 0);
  endtask

  task automatic print(input string tag, input int base, input int m, input int n,
                       input bit rnd, input string exp);
    string got = "";
    int nrd = 0, first_rd = -1, first_tx = -1, dones = 0, end_c = 3000;
    bit addr_ok = 1'b1, stall_ok = 1'b1, prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    base_addr = 9'(base);
    dim_m = 3'(m);
    dim_n = 3'(n);
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < end_c; c++) begin
      if (rd_en) begin
        if (rd_addr !== 9'((base + nrd) % 512)) addr_ok = 1'b0;
        nrd++;
        if (first_rd < 0) first_rd = c;
      end
      if (prev_stall && (tx_valid !== 1'b1 || tx_byte !== prev_byte)) stall_ok = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (end_c == 3000) end_c = c + 3;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = tx_valid && !tx_ready;
      prev_byte = tx_byte;
      if (tx_valid) begin
        if (first_tx < 0) first_tx = c;
        if (tx_ready) got = $sformatf("%s%c", got, tx_byte);
      end
      @(negedge clk);
    end
    tx_ready = 1'b1;
    chks({tag, " stream"}, got, exp);
    chk({tag, " done pulses"}, dones, 1);
    chk({tag, " reads"}, nrd, m * n);
    chk({tag, " addr order"}, addr_ok, 1);
    chk({tag, " stall stable"}, stall_ok, 1);
    chk({tag, " first rd_en"}, first_rd, 0);
    chk({tag, " first tx latency"}, first_tx >= 0 && first_tx <= 13, 1);
    chk({tag, " idle after"}, busy, 0);
  endtask

  task automatic kick_partial(input int cycles);
    base_addr = 9'd10;
    dim_m = 3'd2;
    dim_n = 3'd3;
    tx_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  localparam string ROWS23 = "1 2 3\015\n4 5 6\015\n";
  localparam string ROWS55 = {"-12 -11 -10 -9 -8\015\n-7 -6 -5 -4 -3\015\n",
                              "-2 -1 0 1 2\015\n3 4 5 6 7\015\n8 9 10 11 12\015\n"};

  initial begin
    for (int k = 0; k < 512; k++) ram[k] = '0;
    for (int k = 0; k < 6; k++) ram[10+k] = 32'(k + 1);
    ram[21] = 32'h8000_0000;
    ram[30] = 32'hFFFF_FFFF;
    ram[31] = 32'd1000000000;
    for (int k = 0; k < 25; k++) ram[100+k] = 32'(k - 12);
    ram[510] = 32'd7;
    ram[511] = 32'd8;
    ram[0] = 32'd9;
    ram[1] = 32'd10;
    repeat (2) @(negedge clk);
    outs_zero("reset outputs");
    rst_n = 1'b1;
    @(negedge clk);
    outs_zero("idle outputs");

    print("m2x3", 10, 2, 3, 1'b0, ROWS23);
    print("zero_min", 20, 1, 2, 1'b0, "0 -2147483648\015\n");
    print("minus1", 30, 1, 1, 1'b0, "-1\015\n");
    print("billion", 31, 1, 1, 1'b0, "1000000000\015\n");
    print("m5x5", 100, 5, 5, 1'b0, ROWS55);
    print("m5x5 stall", 100, 5, 5, 1'b1, ROWS55);

    dim_m = 3'd0;
    dim_n = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dim_m0 dim_err", {dim_err, rd_en, tx_valid, busy}, 4'b1000);
    @(negedge clk);
    chk("dim_m0 quiet", {dim_err, rd_en, tx_valid, busy}, 4'b0000);
    dim_m = 3'd2;
    dim_n = 3'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dim_n6 dim_err", {dim_err, rd_en, tx_valid, busy}, 4'b1000);
    @(negedge clk);
    chk("dim_n6 quiet", {dim_err, rd_en, tx_valid, busy}, 4'b0000);

    print("wrap", 510, 2, 2, 1'b0, "7 8\015\n9 10\015\n");

    kick_partial(20);
    chk("en mid busy", busy, 1);
    en = 1'b0;
    @(negedge clk);
    outs_zero("en low outputs");
    en = 1'b1;
    @(negedge clk);
    print("after en", 10, 2, 3, 1'b0, ROWS23);

    kick_partial(22);
    chk("rst mid busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    outs_zero("rst low outputs");
    rst_n = 1'b1;
    @(negedge clk);
    print("after rst", 10, 2, 3, 1'b0, ROWS23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
